ringbuf_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the byte ring buffer (UART TX/RX staging FIFO) among N_REQ byte producers.
- Latches the winning byte and drives the ring buffer's order/data pair.
- Waits for the buffer's one-cycle done pulse.
- Retries after a fixed back-off when the buffer is full.
- Acks the requester on success.
- Sits between the core's I/O producers (e.g. the out-instruction unit and debug dump) and the ring buffer instance.

---
 rtl/ringbuf_write_arbiter_pkg.sv | 21 ++
 rtl/ringbuf_write_arbiter_rr_pick.sv | 37 +++
 rtl/ringbuf_write_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ringbuf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ringbuf_write_arbiter_pkg
// Shared definitions for the ring-buffer write arbiter: default parameter
// values, byte/counter widths and the arbiter state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package ringbuf_write_arbiter_pkg;

    localparam int DEF_LEN_REQ_ID = 2;
    localparam int DEF_BACKOFF    = 4;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ringbuf_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  N_REQ  one-hot priority pointer (highest priority position)
//   grant out N_REQ  one-hot winner: first set req bit at or after ptr,
//                    wrapping modulo N_REQ; zero when req is zero
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    localparam logic [2*N_REQ-1:0] DBL_ONE = (2*N_REQ)'(1);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] mask_dbl;
    logic [2*N_REQ-1:0] masked;
    logic [2*N_REQ-1:0] lowest;

    // The request vector is duplicated so that a search starting at ptr can
    // run past the top bit and continue from bit 0 in the upper copy.
    // ~(ptr - 1) keeps the ptr position and everything above it, which covers
    // the low copy from ptr upward plus the whole upper copy (the wrap).
    assign req_dbl  = {req, req};
    assign mask_dbl = ~({{N_REQ{1'b0}}, ptr} - DBL_ONE);
    assign masked   = req_dbl & mask_dbl;

    // Isolate the lowest set bit (x & -x), then fold both copies together.
    assign lowest = masked & (~masked + DBL_ONE);
    assign grant  = lowest[N_REQ-1:0] | lowest[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/ringbuf_write_arbiter.sv
// ---------------------------------------------------------------------------
// ringbuf_write_arbiter
// Round-robin arbiter sharing the single write port of the byte ring buffer
// among N_REQ byte producers. The winning byte is latched, presented to the
// buffer for one order cycle, and the requester is acked on the buffer's done
// pulse. A missing done (buffer full) triggers a fixed back-off and a retry of
// the same byte without re-arbitration.
// Ports:
//   clk        in   1             clock
//   rstn       in   1             synchronous active-low reset
//   req        in   N_REQ         per-requester request level, held until ack
//   req_data   in   N_REQ*8       byte of requester k on bits [8k+7:8k]
//   ack        out  N_REQ         one-hot one-cycle write-complete pulse
//   buf_order  out  1             ring buffer write strobe
//   buf_data   out  8             ring buffer write data
//   buf_done   in   1             ring buffer done (one cycle after order)
//   grant_id   out  LEN_REQ_ID    index of current/last granted requester
//   busy       out  1             high whenever not IDLE
// ---------------------------------------------------------------------------
module ringbuf_write_arbiter
    import ringbuf_write_arbiter_pkg::*;
#(
    parameter  int LEN_REQ_ID = DEF_LEN_REQ_ID,
    parameter  int BACKOFF    = DEF_BACKOFF,
    localparam int N_REQ      = 2 ** LEN_REQ_ID
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*BYTE_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    buf_order,
    output logic [BYTE_W-1:0]       buf_data,
    input  logic                    buf_done,
    output logic [LEN_REQ_ID-1:0]   grant_id,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(BACKOFF - 1);

    arb_state_t              state;
    logic [N_REQ-1:0]        ptr;
    logic [N_REQ-1:0]        winner_oh;
    logic [CNT_W-1:0]        cnt;

    logic [N_REQ-1:0]        pick_oh;
    logic [LEN_REQ_ID-1:0]   pick_id;
    logic [BYTE_W-1:0]       pick_byte;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_oh)
    );

    // One-hot to binary index and byte mux for the candidate winner; pick_oh
    // is one-hot or zero, so OR-accumulation is exact.
    always_comb begin
        pick_id   = '0;
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_id   = pick_id | LEN_REQ_ID'(i);
                pick_byte = pick_byte | req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Arbiter FSM. The pointer advances only on a successful write, so a
    // requester stuck behind a full buffer keeps its turn across retries.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            ptr       <= N_REQ'(1);
            winner_oh <= '0;
            grant_id  <= '0;
            buf_data  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        winner_oh <= pick_oh;
                        grant_id  <= pick_id;
                        buf_data  <= pick_byte;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (buf_done) begin
                        ptr   <= {winner_oh[N_REQ-2:0], winner_oh[N_REQ-1]};
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= BACKOFF_LOAD;
                        state <= ST_BACKOFF;
                    end
                end
                ST_BACKOFF: begin
                    if (cnt == '0) begin
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Order and busy decode straight from the state register; ack must land
    // in the same cycle as done, so it is gated combinationally.
    assign buf_order = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign ack       = (state == ST_WAIT && buf_done) ? winner_oh : '0;

endmodule
